// File: rtl/joy_cmd_decoder.sv
`default_nettype none
// ---------------------------------------------------------------------------
// joy_cmd_decoder - joystick debounce, opposite-direction cancel, board
// mirror and one-cycle command pulses.  Optional direction auto-repeat is
// built when JOY_AUTOREPEAT_EN is defined.                       Rev 1.0
// ---------------------------------------------------------------------------
module joy_cmd_decoder #(
    parameter int DEBOUNCE_CYC = 250000,
    parameter int REPEAT_DELAY = 10000000,
    parameter int REPEAT_RATE  = 2500000
) (
    input  logic        Clk,
    input  logic        reset,
    input  logic [15:0] joy_raw,
    input  logic        enable,
    input  logic        mirror,
    output logic [8:0]  cmd,
    output logic [8:0]  held,
    output logic        any_dir_held
);

    localparam int DW = $clog2(DEBOUNCE_CYC + 1);

    logic [8:0]    stable_q, stable_d;
    logic [DW-1:0] dcnt_q [9];
    logic [DW-1:0] dcnt_d [9];
    logic [8:0]    eff_q, eff_d, rise;
    logic [3:0]    rep_d;
    logic [8:0]    cmd_q, cmd_d;
    logic [8:0]    held_q, held_d;
    logic          adh_q;
    logic          unused_raw;

    assign unused_raw = ^joy_raw[15:9];

    function automatic logic [8:0] cancel_dirs(input logic [8:0] s);
        logic [8:0] r;
        r    = s;
        r[0] = s[0] & ~s[1];
        r[1] = s[1] & ~s[0];
        r[2] = s[2] & ~s[3];
        r[3] = s[3] & ~s[2];
        return r;
    endfunction

    // Black-side view: up<->down, left<->right; buttons untouched.
    function automatic logic [8:0] remap(input logic [8:0] v, input logic m);
        logic [8:0] r;
        r = v;
        if (m) begin
            r[3:0] = {v[2], v[3], v[0], v[1]};
        end
        return r;
    endfunction

    always_comb begin
        stable_d = stable_q;
        for (int i = 0; i < 9; i++) begin
            dcnt_d[i] = '0;
            if (joy_raw[i] != stable_q[i]) begin
                if (dcnt_q[i] == DW'(DEBOUNCE_CYC - 1)) begin
                    stable_d[i] = ~stable_q[i];
                end else begin
                    dcnt_d[i] = dcnt_q[i] + 1'b1;
                end
            end
        end
    end

    // Edges are taken on the unmirrored levels so a mirror flip never pulses.
    assign eff_d  = cancel_dirs(stable_d);
    assign rise   = eff_d & ~eff_q;
    assign held_d = remap(eff_d, mirror);
    assign cmd_d  = enable ? remap(rise | {5'b0, rep_d}, mirror) : '0;

`ifdef JOY_AUTOREPEAT_EN
    localparam int RMAX = (REPEAT_DELAY > REPEAT_RATE) ? REPEAT_DELAY : REPEAT_RATE;
    localparam int RW   = $clog2(RMAX + 1);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_DELAY  = 2'd1,
        S_REPEAT = 2'd2
    } rpt_state_t;

    rpt_state_t    state_q, state_d;
    logic [RW-1:0] rcnt_q, rcnt_d;

    always_comb begin
        state_d = state_q;
        rcnt_d  = rcnt_q;
        rep_d   = '0;
        if (!enable || (eff_d[3:0] == 4'b0000)) begin
            state_d = S_IDLE;
            rcnt_d  = '0;
        end else if (rise[3:0] != 4'b0000) begin
            state_d = S_DELAY;
            rcnt_d  = RW'(REPEAT_DELAY);
        end else if (state_q != S_IDLE) begin
            if (rcnt_q == RW'(1)) begin
                state_d = S_REPEAT;
                rcnt_d  = RW'(REPEAT_RATE);
                rep_d   = eff_d[3:0];
            end else begin
                rcnt_d = rcnt_q - 1'b1;
            end
        end
    end

    always_ff @(posedge Clk) begin
        if (reset) begin
            state_q <= S_IDLE;
            rcnt_q  <= '0;
        end else begin
            state_q <= state_d;
            rcnt_q  <= rcnt_d;
        end
    end
`else
    assign rep_d = 4'b0000;
`endif

    always_ff @(posedge Clk) begin
        if (reset) begin
            stable_q <= '0;
            eff_q    <= '0;
            cmd_q    <= '0;
            held_q   <= '0;
            adh_q    <= 1'b0;
            for (int i = 0; i < 9; i++) begin
                dcnt_q[i] <= '0;
            end
        end else begin
            stable_q <= stable_d;
            eff_q    <= eff_d;
            cmd_q    <= cmd_d;
            held_q   <= held_d;
            adh_q    <= |held_d[3:0];
            for (int i = 0; i < 9; i++) begin
                dcnt_q[i] <= dcnt_d[i];
            end
        end
    end

    assign cmd          = cmd_q;
    assign held         = held_q;
    assign any_dir_held = adh_q;

endmodule
`default_nettype wire

// File: tb/tb_joy_cmd_decoder.sv
`default_nettype none
// Testbench for joy_cmd_decoder: single-press vector table plus a pulse
// scoreboard keyed on the cycle each command pulse must appear.
module tb_joy_cmd_decoder;

    localparam int DEB   = 4;
    localparam int RDLY  = 20;
    localparam int RRATE = 8;

    logic        Clk = 1'b0;
    logic        reset;
    logic [15:0] joy_raw;
    logic        enable;
    logic        mirror;
    logic [8:0]  cmd;
    logic [8:0]  held;
    logic        any_dir_held;

    joy_cmd_decoder #(
        .DEBOUNCE_CYC(DEB),
        .REPEAT_DELAY(RDLY),
        .REPEAT_RATE (RRATE)
    ) dut (
        .Clk         (Clk),
        .reset       (reset),
        .joy_raw     (joy_raw),
        .enable      (enable),
        .mirror      (mirror),
        .cmd         (cmd),
        .held        (held),
        .any_dir_held(any_dir_held)
    );

    always #5 Clk = ~Clk;

    int cyc = 0;
    always @(posedge Clk) cyc <= cyc + 1;

    int checks = 0;
    int errors = 0;
    bit mon_en = 1'b0;

    typedef struct {
        int         cyc;
        logic [8:0] cmd;
    } exp_t;

    typedef struct {
        logic [15:0] raw;
        logic        mir;
        logic [8:0]  exp_cmd;
        logic [8:0]  exp_held;
    } vec_t;

    exp_t sb[$];
    vec_t vecs[16];

    task automatic check(input string name, input int got, input int exp);
        checks++;
        if (got != exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, got, exp);
        end
    endtask

    task automatic push(input int c, input logic [8:0] m);
        exp_t e;
        e.cyc = c;
        e.cmd = m;
        sb.push_back(e);
    endtask

    task automatic drive(input logic [15:0] r, input logic en, input logic m, input int n);
        joy_raw = r;
        enable  = en;
        mirror  = m;
        repeat (n) @(negedge Clk);
    endtask

    // Every monitored cycle: either the scheduled pulse or a quiet cmd bus.
    always @(negedge Clk) begin
        if (mon_en) begin
            if (sb.size() != 0 && sb[0].cyc == cyc) begin
                check($sformatf("cmd_at_cyc%0d", cyc), int'(cmd), int'(sb[0].cmd));
                void'(sb.pop_front());
            end else begin
                check($sformatf("quiet_cmd_at_cyc%0d", cyc), int'(cmd), 0);
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, cyc=%0d", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        int t;

        vecs[0]  = '{16'h0010, 1'b0, 9'h010, 9'h010};
        vecs[1]  = '{16'h0020, 1'b0, 9'h020, 9'h020};
        vecs[2]  = '{16'h0040, 1'b0, 9'h040, 9'h040};
        vecs[3]  = '{16'h0080, 1'b0, 9'h080, 9'h080};
        vecs[4]  = '{16'h0100, 1'b0, 9'h100, 9'h100};
        vecs[5]  = '{16'h0001, 1'b0, 9'h001, 9'h001};
        vecs[6]  = '{16'h0002, 1'b0, 9'h002, 9'h002};
        vecs[7]  = '{16'h0004, 1'b0, 9'h004, 9'h004};
        vecs[8]  = '{16'h0008, 1'b0, 9'h008, 9'h008};
        vecs[9]  = '{16'h0001, 1'b1, 9'h002, 9'h002};
        vecs[10] = '{16'h0008, 1'b1, 9'h004, 9'h004};
        vecs[11] = '{16'h000C, 1'b0, 9'h000, 9'h000};
        vecs[12] = '{16'h0003, 1'b1, 9'h000, 9'h000};
        vecs[13] = '{16'h0050, 1'b0, 9'h050, 9'h050};
        vecs[14] = '{16'hFE00, 1'b0, 9'h000, 9'h000};
        vecs[15] = '{16'h0011, 1'b0, 9'h011, 9'h011};

        // Reset with action and both axis pairs held through it.
        reset   = 1'b1;
        joy_raw = 16'h001F;
        enable  = 1'b1;
        mirror  = 1'b0;
        repeat (3) @(negedge Clk);
        mon_en = 1'b1;
        check("reset_cmd", int'(cmd), 0);
        check("reset_held", int'(held), 0);
        check("reset_adh", int'(any_dir_held), 0);
        reset = 1'b0;
        t = cyc;
        push(t + DEB, 9'h010);
        repeat (6) @(negedge Clk);
        check("post_reset_held", int'(held), 9'h010);
        check("post_reset_adh", int'(any_dir_held), 0);
        drive(16'h0000, 1'b1, 1'b0, 6);

        foreach (vecs[i]) begin
            t = cyc;
            if (vecs[i].exp_cmd != 9'h000) push(t + DEB, vecs[i].exp_cmd);
            drive(vecs[i].raw, 1'b1, vecs[i].mir, 6);
            check($sformatf("vec%0d_held", i), int'(held), int'(vecs[i].exp_held));
            check($sformatf("vec%0d_adh", i), int'(any_dir_held), int'(|vecs[i].exp_held[3:0]));
            drive(16'h0000, 1'b1, vecs[i].mir, 6);
            check($sformatf("vec%0d_held_released", i), int'(held), 0);
        end

        // Short glitch never pulses; long press pulses once, release lags by DEB.
        drive(16'h0010, 1'b1, 1'b0, 3);
        drive(16'h0000, 1'b1, 1'b0, 5);
        check("glitch_held", int'(held), 0);
        t = cyc;
        push(t + DEB, 9'h010);
        drive(16'h0010, 1'b1, 1'b0, 10);
        check("action_held", int'(held), 9'h010);
        drive(16'h0000, 1'b1, 1'b0, 3);
        check("action_held_3_after_release", int'(held), 9'h010);
        drive(16'h0000, 1'b1, 1'b0, 1);
        check("action_held_4_after_release", int'(held), 0);
        drive(16'h0000, 1'b1, 1'b0, 4);

        // Right held 60 cycles.
        t = cyc;
        push(t + DEB, 9'h001);
`ifdef JOY_AUTOREPEAT_EN
        for (int k = 0; k < 5; k++) push(t + DEB + RDLY + RRATE * k, 9'h001);
`endif
        drive(16'h0001, 1'b1, 1'b0, 60);
        check("right_long_held", int'(held), 9'h001);
        check("right_long_adh", int'(any_dir_held), 1);
        drive(16'h0000, 1'b1, 1'b0, 25);
        check("right_long_released", int'(held), 0);

        // Up+down cancel, then releasing down exposes up.
        drive(16'h000C, 1'b1, 1'b0, 10);
        check("updown_held", int'(held), 0);
        check("updown_adh", int'(any_dir_held), 0);
        t = cyc;
        push(t + DEB, 9'h008);
        drive(16'h0008, 1'b1, 1'b0, 10);
        check("up_after_down_release_held", int'(held), 9'h008);
        drive(16'h0000, 1'b1, 1'b0, 8);

        // Mirrored right, then flip mirror mid-hold.
        t = cyc;
        push(t + DEB, 9'h002);
        drive(16'h0001, 1'b1, 1'b1, 8);
        check("mirror_right_held", int'(held), 9'h002);
        drive(16'h0001, 1'b1, 1'b0, 1);
        check("mirror_flip_held", int'(held), 9'h001);
        drive(16'h0001, 1'b1, 1'b0, 3);
        drive(16'h0000, 1'b1, 1'b0, 8);

        // Disabled press, re-enable mid-hold, then a fresh press.
        drive(16'h0010, 1'b0, 1'b0, 8);
        check("disabled_held", int'(held), 9'h010);
        drive(16'h0010, 1'b1, 1'b0, 4);
        drive(16'h0000, 1'b1, 1'b0, 6);
        t = cyc;
        push(t + DEB, 9'h010);
        drive(16'h0010, 1'b1, 1'b0, 6);
        drive(16'h0000, 1'b1, 1'b0, 6);

        // Reset while repeating with right held.
        t = cyc;
        push(t + DEB, 9'h001);
`ifdef JOY_AUTOREPEAT_EN
        push(t + DEB + RDLY, 9'h001);
        push(t + DEB + RDLY + RRATE, 9'h001);
`endif
        drive(16'h0001, 1'b1, 1'b0, 34);
        reset = 1'b1;
        @(negedge Clk);
        check("midrun_reset_cmd", int'(cmd), 0);
        check("midrun_reset_held", int'(held), 0);
        check("midrun_reset_adh", int'(any_dir_held), 0);
        reset = 1'b0;
        t = cyc;
        push(t + DEB, 9'h001);
`ifdef JOY_AUTOREPEAT_EN
        push(t + DEB + RDLY, 9'h001);
`endif
        drive(16'h0001, 1'b1, 1'b0, 26);
        check("after_reset_right_held", int'(held), 9'h001);
        drive(16'h0000, 1'b1, 1'b0, 12);

        check("scoreboard_drained", sb.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
